// File: rtl/data_gen_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : data_gen_dispatch
// Brief    : Fans reordered activation beats out to LANES PE lanes (conv
//            broadcast, depthwise per-lane fill, pointwise tap-0, zero-fill)
//            through a two-stage valid/ready pipeline.
// Option   : DATA_GEN_LANE_MASK_EN adds a per-lane zeroing mask port.
// Revision : 1.0 - initial release
// ============================================================================
module data_gen_dispatch #(
    parameter int LANES  = 16,
    parameter int TAPS   = 9,
    parameter int DW     = 32,
    parameter int TYPE_W = 7,
    parameter int PARA_W = 8
) (
    input  logic                     clk_100M,
    input  logic                     rst_n,
    input  logic                     in_vld,
    output logic                     in_rdy,
    input  logic [TYPE_W-1:0]        in_layer_type,
    input  logic                     in_calc_en,
    input  logic                     in_acc_s,
    input  logic [PARA_W-1:0]        in_acc_para,
    input  logic [TAPS*DW-1:0]       in_data,
`ifdef DATA_GEN_LANE_MASK_EN
    input  logic [LANES-1:0]         lane_mask,
`endif
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic                     out_vld_for_w,
    output logic                     out_acc_s,
    output logic [PARA_W-1:0]        out_acc_para,
    output logic [LANES*TAPS*DW-1:0] out_data,
    output logic                     err_partial
);

    localparam int LW    = TAPS * DW;
    localparam int BW    = LANES * LW;
    localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [CNT_W-1:0]  LAST_LANE = CNT_W'(LANES - 1);
    localparam logic [TYPE_W-1:0] LT_CONV   = TYPE_W'(0);
    localparam logic [TYPE_W-1:0] LT_DW     = TYPE_W'(1);
    localparam logic [TYPE_W-1:0] LT_PW     = TYPE_W'(2);

    logic                 rdy_en;
    logic                 s1_vld;
    logic [BW-1:0]        s1_data;
    logic                 s1_acc_s;
    logic [PARA_W-1:0]    s1_acc_para;
    logic [CNT_W-1:0]     lane_cnt;
    logic [BW-LW-1:0]     dw_buf;

    logic                 s2_load;
    logic                 s1_adv;
    logic                 accept;
    logic                 is_dw;
    logic                 dw_last;
    logic                 s1_load;
    logic [BW-1:0]        asm_data;

    assign s2_load       = !out_vld || out_rdy;
    assign s1_adv        = s1_vld && s2_load;
    // rdy_en keeps in_rdy low for the first cycle out of reset.
    assign in_rdy        = rdy_en && (!s1_vld || s1_adv);
    assign accept        = in_vld && in_rdy;
    assign is_dw         = (in_layer_type == LT_DW);
    assign dw_last       = (lane_cnt == LAST_LANE);
    assign s1_load       = accept && in_calc_en && (!is_dw || dw_last);
    assign out_vld_for_w = s1_adv;

    // AVGPL, PW_SC and any undefined type fall through to all-zero lanes.
    always_comb begin
        asm_data = '0;
        case (in_layer_type)
            LT_CONV: begin
                for (int l = 0; l < LANES; l++) begin
                    asm_data[l*LW +: LW] = in_data;
                end
            end
            LT_PW: begin
                for (int l = 0; l < LANES; l++) begin
                    asm_data[l*LW +: DW] = in_data[DW-1:0];
                end
            end
            LT_DW:   asm_data = {in_data, dw_buf};
            default: asm_data = '0;
        endcase
`ifdef DATA_GEN_LANE_MASK_EN
        for (int l = 0; l < LANES; l++) begin
            if (!lane_mask[l]) begin
                asm_data[l*LW +: LW] = '0;
            end
        end
`endif
    end

    always_ff @(posedge clk_100M) begin
        if (!rst_n) begin
            rdy_en      <= 1'b0;
            s1_vld      <= 1'b0;
            s1_data     <= '0;
            s1_acc_s    <= 1'b0;
            s1_acc_para <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (s1_load) begin
                s1_vld      <= 1'b1;
                s1_data     <= asm_data;
                s1_acc_s    <= in_acc_s;
                s1_acc_para <= in_acc_para;
            end else if (s1_adv) begin
                s1_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_100M) begin
        if (!rst_n) begin
            out_vld      <= 1'b0;
            out_data     <= '0;
            out_acc_s    <= 1'b0;
            out_acc_para <= '0;
        end else if (s2_load) begin
            out_vld <= s1_vld;
            if (s1_vld) begin
                out_data     <= s1_data;
                out_acc_s    <= s1_acc_s;
                out_acc_para <= s1_acc_para;
            end
        end
    end

    // The last depthwise lane is taken straight from in_data, so the buffer
    // only holds lanes 0..LANES-2.
    always_ff @(posedge clk_100M) begin
        if (!rst_n) begin
            lane_cnt    <= '0;
            dw_buf      <= '0;
            err_partial <= 1'b0;
        end else if (accept) begin
            if (is_dw) begin
                if (dw_last) begin
                    lane_cnt <= '0;
                end else begin
                    lane_cnt <= lane_cnt + CNT_W'(1);
                    for (int l = 0; l < LANES - 1; l++) begin
                        if (lane_cnt == CNT_W'(l)) begin
                            dw_buf[l*LW +: LW] <= in_data;
                        end
                    end
                end
            end else if (lane_cnt != '0) begin
                lane_cnt    <= '0;
                err_partial <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_gen_dispatch.sv
`timescale 1ns/1ps
module tb_data_gen_dispatch;

    localparam int LANES  = 16;
    localparam int TAPS   = 9;
    localparam int DW     = 32;
    localparam int TYPE_W = 7;
    localparam int PARA_W = 8;
    localparam int LW     = TAPS * DW;
    localparam int BW     = LANES * LW;

    logic              clk_100M = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_vld = 1'b0;
    logic              in_rdy;
    logic [TYPE_W-1:0] in_layer_type = '0;
    logic              in_calc_en = 1'b0;
    logic              in_acc_s = 1'b0;
    logic [PARA_W-1:0] in_acc_para = '0;
    logic [LW-1:0]     in_data = '0;
    logic              out_vld;
    logic              out_rdy = 1'b1;
    logic              out_vld_for_w;
    logic              out_acc_s;
    logic [PARA_W-1:0] out_acc_para;
    logic [BW-1:0]     out_data;
    logic              err_partial;
`ifdef DATA_GEN_LANE_MASK_EN
    logic [LANES-1:0]  lane_mask = '1;
`endif

    data_gen_dispatch #(
        .LANES(LANES), .TAPS(TAPS), .DW(DW), .TYPE_W(TYPE_W), .PARA_W(PARA_W)
    ) dut (
        .clk_100M      (clk_100M),
        .rst_n         (rst_n),
        .in_vld        (in_vld),
        .in_rdy        (in_rdy),
        .in_layer_type (in_layer_type),
        .in_calc_en    (in_calc_en),
        .in_acc_s      (in_acc_s),
        .in_acc_para   (in_acc_para),
        .in_data       (in_data),
`ifdef DATA_GEN_LANE_MASK_EN
        .lane_mask     (lane_mask),
`endif
        .out_vld       (out_vld),
        .out_rdy       (out_rdy),
        .out_vld_for_w (out_vld_for_w),
        .out_acc_s     (out_acc_s),
        .out_acc_para  (out_acc_para),
        .out_data      (out_data),
        .err_partial   (err_partial)
    );

    always #5 clk_100M = ~clk_100M;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [BW-1:0]     data;
        logic              acc_s;
        logic [PARA_W-1:0] para;
    } beat_t;

    beat_t         q[$];
    logic [LW-1:0] mbuf [LANES];
    int            mcnt = 0;
    bit            err_m = 1'b0;
    bit            rdy_m = 1'b0;
    int            beats_out = 0;
    int            forw_cnt = 0;
    logic [BW-1:0] last_out = '0;
    bit            rdy_rand = 1'b0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] word_of(input logic [BW-1:0] v, input int lane, input int tap);
        return v[(lane*TAPS + tap)*DW +: DW];
    endfunction

    function automatic logic [LW-1:0] rand_win();
        logic [LW-1:0] w;
        for (int k = 0; k < TAPS; k++) w[k*DW +: DW] = $urandom;
        return w;
    endfunction

    // Reference: what one accepted beat contributes to the output stream.
    task automatic model_accept(input int ty, input logic [LW-1:0] d, input bit calc,
                                input bit s, input logic [PARA_W-1:0] p);
        beat_t b;
        bit    produce;
        b.data  = '0;
        b.acc_s = s;
        b.para  = p;
        produce = 1'b0;
        if (ty == 1) begin
            mbuf[mcnt] = d;
            if (mcnt == LANES - 1) begin
                for (int l = 0; l < LANES; l++) b.data[l*LW +: LW] = mbuf[l];
                mcnt    = 0;
                produce = calc;
            end else begin
                mcnt++;
            end
        end else begin
            if (mcnt != 0) begin
                err_m = 1'b1;
                mcnt  = 0;
            end
            produce = calc;
            if (ty == 0) begin
                for (int l = 0; l < LANES; l++) b.data[l*LW +: LW] = d;
            end else if (ty == 2) begin
                for (int l = 0; l < LANES; l++) b.data[l*LW +: DW] = d[DW-1:0];
            end
        end
        if (produce) q.push_back(b);
    endtask

    // Compare process: checks the state left by the last edge, then
    // advances the model by what the coming edge will do.
    initial begin : monitor
        bit                p_vld, p_rdy, p_forw, p_s, new_beat, ok;
        logic [BW-1:0]     p_data;
        logic [PARA_W-1:0] p_para;
        beat_t             b;
        int                bad, idx;
        p_vld = 0; p_rdy = 0; p_forw = 0; p_s = 0; p_data = '0; p_para = '0;
        forever begin
            @(negedge clk_100M);
            chk(in_rdy === (rdy_m && (q.size() < 2 || out_rdy)), "in_rdy", 64'(in_rdy),
                64'(rdy_m && (q.size() < 2 || out_rdy)));
            chk(err_partial === err_m, "err_partial", 64'(err_partial), 64'(err_m));
            new_beat = out_vld && (!p_vld || p_rdy);
            chk(new_beat == p_forw, "for_w_lead", 64'(p_forw), 64'(new_beat));
            if (out_vld) chk(q.size() != 0, "out_vld_without_beat", 64'(out_vld), 64'(0));
            if (p_vld && !p_rdy)
                chk(out_vld && out_data === p_data && out_acc_s === p_s && out_acc_para === p_para,
                    "stall_hold", 64'(out_data[DW-1:0]), 64'(p_data[DW-1:0]));
            if (rst_n && out_vld_for_w) forw_cnt++;
            if (!rst_n) begin
                q.delete();
                mcnt = 0; err_m = 0; rdy_m = 0;
                p_vld = 0; p_rdy = 0; p_forw = 0;
            end else begin
                if (out_vld && out_rdy && q.size() != 0) begin
                    b   = q.pop_front();
                    bad = -1;
                    for (int w = 0; w < LANES*TAPS; w++)
                        if (bad < 0 && out_data[w*DW +: DW] !== b.data[w*DW +: DW]) bad = w;
                    ok  = (bad < 0) && out_acc_s === b.acc_s && out_acc_para === b.para;
                    idx = (bad < 0) ? 0 : bad;
                    chk(ok, "beat", {23'd0, out_acc_s, out_acc_para, out_data[idx*DW +: DW]},
                        {23'd0, b.acc_s, b.para, b.data[idx*DW +: DW]});
                    beats_out++;
                    last_out = out_data;
                end
                if (in_vld && in_rdy)
                    model_accept(int'(in_layer_type), in_data, in_calc_en, in_acc_s, in_acc_para);
                rdy_m  = 1'b1;
                p_vld  = out_vld; p_rdy = out_rdy; p_forw = out_vld_for_w;
                p_data = out_data; p_s = out_acc_s; p_para = out_acc_para;
            end
        end
    end

    initial begin : rdy_driver
        forever begin
            @(posedge clk_100M);
            #1;
            if (rdy_rand) out_rdy = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin : watchdog
        #1_000_000;
        failures++;
        $display("FAIL watchdog_timeout actual=%0t required=<1000000", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Called and returns at posedge+1.
    task automatic send(input int ty, input logic [LW-1:0] d, input bit calc,
                        input bit s, input logic [PARA_W-1:0] p);
        int n;
        bit took;
        n = 0; took = 0;
        in_vld = 1'b1; in_layer_type = TYPE_W'(ty); in_data = d;
        in_calc_en = calc; in_acc_s = s; in_acc_para = p;
        while (!took && n < 300) begin
            @(negedge clk_100M);
            took = in_rdy;
            @(posedge clk_100M);
            #1;
            n++;
        end
        if (!took) chk(1'b0 == took && n < 300, "send_timeout", 64'(n), 64'(300));
        in_vld = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q.size() != 0 || out_vld) && n < 400) begin
            @(posedge clk_100M);
            #1;
            n++;
        end
        chk(n < 400, "drain_timeout", 64'(n), 64'(400));
        repeat (3) begin @(posedge clk_100M); #1; end
    endtask

    initial begin : main
        logic [LW-1:0] d;
        logic [BW-1:0] e;
        logic [LW-1:0] win [4];
        int b0, f0, kind, len, ty, r;

        rst_n = 1'b0; out_rdy = 1'b1;
        repeat (2) @(posedge clk_100M);
        @(negedge clk_100M);
        chk(out_vld === 1'b0, "rst_out_vld", 64'(out_vld), 0);
        chk(in_rdy === 1'b0, "rst_in_rdy", 64'(in_rdy), 0);
        chk(err_partial === 1'b0, "rst_err", 64'(err_partial), 0);
        chk(out_vld_for_w === 1'b0, "rst_for_w", 64'(out_vld_for_w), 0);
        chk(out_data === '0 && out_acc_s === 1'b0, "rst_out_data", 64'(out_data[63:0]), 0);
        chk(out_acc_para === '0, "rst_acc_para", 64'(out_acc_para), 0);
        @(posedge clk_100M); #1 rst_n = 1'b1;
        @(posedge clk_100M); #1;

        // CONV latency and broadcast
        for (int k = 0; k < TAPS; k++) d[k*DW +: DW] = 32'(k + 1);
        in_vld = 1'b1; in_layer_type = '0; in_data = d; in_calc_en = 1'b1;
        in_acc_s = 1'b1; in_acc_para = 8'h05;
        @(negedge clk_100M);
        chk(in_rdy === 1'b1, "t1_in_rdy", 64'(in_rdy), 1);
        @(posedge clk_100M); #1 in_vld = 1'b0;
        @(negedge clk_100M);
        chk(out_vld_for_w === 1'b1, "t1_for_w", 64'(out_vld_for_w), 1);
        chk(out_vld === 1'b0, "t1_no_early_vld", 64'(out_vld), 0);
        @(posedge clk_100M); #1;
        @(negedge clk_100M);
        for (int l = 0; l < LANES; l++) e[l*LW +: LW] = d;
        chk(out_vld === 1'b1, "t1_out_vld", 64'(out_vld), 1);
        chk(out_data === e, "t1_out_data", 64'(out_data[63:0]), 64'(e[63:0]));
        chk(word_of(out_data, 15, 8) === 32'd9, "t1_lane15_tap8", 64'(word_of(out_data, 15, 8)), 9);
        chk(out_acc_para === 8'h05, "t1_acc_para", 64'(out_acc_para), 5);
        @(posedge clk_100M); #1;
        wait_idle();

        // Depthwise fill: 16 beats -> one output
        b0 = beats_out; f0 = forw_cnt;
        for (int n = 0; n < LANES; n++) send(1, {TAPS{32'(n)}}, 1'b1, 1'b0, 8'h11);
        wait_idle();
        chk(beats_out - b0 == 1, "t2_beat_count", 64'(beats_out - b0), 1);
        chk(forw_cnt - f0 == 1, "t2_for_w_count", 64'(forw_cnt - f0), 1);
        chk(word_of(last_out, 5, 3) === 32'd5, "t2_lane5", 64'(word_of(last_out, 5, 3)), 5);
        chk(word_of(last_out, 15, 8) === 32'd15, "t2_lane15", 64'(word_of(last_out, 15, 8)), 15);
        chk(word_of(last_out, 0, 0) === 32'd0, "t2_lane0", 64'(word_of(last_out, 0, 0)), 0);

        // Backpressure with four CONV beats
        out_rdy = 1'b0;
        b0 = beats_out;
        for (int i = 0; i < 4; i++) win[i] = rand_win();
        fork
            begin
                for (int i = 0; i < 4; i++) send(0, win[i], 1'b1, 1'b0, 8'(i));
            end
            begin
                repeat (5) @(posedge clk_100M);
                #1;
                @(negedge clk_100M);
                chk(in_rdy === 1'b0, "t3_in_rdy_full", 64'(in_rdy), 0);
                chk(out_vld === 1'b1, "t3_out_vld_held", 64'(out_vld), 1);
                @(posedge clk_100M); #1 out_rdy = 1'b1;
            end
        join
        wait_idle();
        chk(beats_out - b0 == 4, "t3_beat_count", 64'(beats_out - b0), 4);
        chk(last_out[LW-1:0] === win[3], "t3_last_beat", 64'(last_out[63:0]), 64'(win[3][63:0]));

        // PW tap-0 broadcast, dropped CONV, zero-fill AVGPL
        d = rand_win(); d[DW-1:0] = 32'hDEADBEEF;
        send(2, d, 1'b1, 1'b1, 8'h22);
        wait_idle();
        chk(word_of(last_out, 0, 0) === 32'hDEADBEEF, "t4_pw_lane0", 64'(word_of(last_out, 0, 0)), 64'hDEADBEEF);
        chk(word_of(last_out, 7, 0) === 32'hDEADBEEF, "t4_pw_lane7", 64'(word_of(last_out, 7, 0)), 64'hDEADBEEF);
        chk(word_of(last_out, 7, 1) === 32'd0, "t4_pw_tap1", 64'(word_of(last_out, 7, 1)), 0);
        b0 = beats_out;
        send(0, rand_win(), 1'b0, 1'b0, 8'h33);
        wait_idle();
        chk(beats_out == b0, "t4_drop", 64'(beats_out - b0), 0);
        send(3, rand_win(), 1'b1, 1'b0, 8'h44);
        wait_idle();
        chk(beats_out - b0 == 1, "t4_avgpl_count", 64'(beats_out - b0), 1);
        chk(last_out === '0, "t4_avgpl_zero", 64'(last_out[63:0]), 0);

        // Abandoned depthwise fill
        for (int n = 0; n < 5; n++) send(1, {TAPS{32'(n + 50)}}, 1'b1, 1'b0, 8'h55);
        b0 = beats_out;
        send(0, rand_win(), 1'b1, 1'b0, 8'h66);
        @(negedge clk_100M);
        chk(err_partial === 1'b1, "t5_err_set", 64'(err_partial), 1);
        @(posedge clk_100M); #1;
        wait_idle();
        chk(beats_out - b0 == 1, "t5_conv_out", 64'(beats_out - b0), 1);
        b0 = beats_out;
        for (int n = 0; n < LANES; n++) send(1, {TAPS{32'(n + 100)}}, 1'b1, 1'b0, 8'h77);
        wait_idle();
        chk(beats_out - b0 == 1, "t5_refill_count", 64'(beats_out - b0), 1);
        chk(word_of(last_out, 0, 0) === 32'd100, "t5_refill_lane0", 64'(word_of(last_out, 0, 0)), 100);
        chk(err_partial === 1'b1, "t5_err_sticky", 64'(err_partial), 1);

        // Randomised traffic with random backpressure
        rdy_rand = 1'b1;
        for (int s = 0; s < 60; s++) begin
            kind = $urandom_range(0, 3);
            if (kind == 0) begin
                len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : LANES;
                for (int n = 0; n < len; n++)
                    send(1, rand_win(), $urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)), 8'($urandom));
            end else begin
                r  = $urandom_range(0, 9);
                ty = (r < 4) ? 0 : (r < 6) ? 2 : (r < 7) ? 3 : (r < 8) ? 4 : $urandom_range(5, 127);
                send(ty, rand_win(), $urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)), 8'($urandom));
            end
        end
        rdy_rand = 1'b0;
        out_rdy  = 1'b1;
        wait_idle();

        // Reset during a stalled output and a partial fill
        out_rdy = 1'b0;
        send(0, rand_win(), 1'b1, 1'b0, 8'h88);
        repeat (2) begin @(posedge clk_100M); #1; end
        for (int n = 0; n < 3; n++) send(1, rand_win(), 1'b1, 1'b0, 8'h99);
        @(negedge clk_100M);
        chk(out_vld === 1'b1, "t6_stalled", 64'(out_vld), 1);
        chk(err_partial === 1'b1, "t6_err_before", 64'(err_partial), 1);
        @(posedge clk_100M); #1 rst_n = 1'b0;
        @(posedge clk_100M); #1 rst_n = 1'b1;
        @(negedge clk_100M);
        chk(out_vld === 1'b0, "t6_out_vld", 64'(out_vld), 0);
        chk(in_rdy === 1'b0, "t6_in_rdy", 64'(in_rdy), 0);
        chk(err_partial === 1'b0, "t6_err", 64'(err_partial), 0);
        @(posedge clk_100M); #1 out_rdy = 1'b1;
        b0 = beats_out;
        repeat (10) begin @(posedge clk_100M); #1; end
        chk(beats_out == b0, "t6_no_stale", 64'(beats_out - b0), 0);
        for (int n = 0; n < LANES; n++) send(1, {TAPS{32'(n + 200)}}, 1'b1, 1'b0, 8'hAA);
        wait_idle();
        chk(beats_out - b0 == 1, "t6_fill_count", 64'(beats_out - b0), 1);
        chk(word_of(last_out, 0, 0) === 32'd200, "t6_lane0", 64'(word_of(last_out, 0, 0)), 200);
        chk(word_of(last_out, 15, 4) === 32'd215, "t6_lane15", 64'(word_of(last_out, 15, 4)), 215);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
